// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Default 640x480@60 timing constants, the horizontal/vertical region state
// enums and a saturating 10-bit increment shared by the VGA receive monitor.
// The FP states encode as zero so a cleared register lands in the front porch.

package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        H_FP_S   = 2'd0,
        H_SYNC_S = 2'd1,
        H_BP_S   = 2'd2,
        H_ACT_S  = 2'd3
    } h_state_e;

    typedef enum logic [1:0] {
        V_FP_S   = 2'd0,
        V_SYNC_S = 2'd1,
        V_BP_S   = 2'd2,
        V_ACT_S  = 2'd3
    } v_state_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
// Two-stage delay of one active-low sync input plus falling-edge detect on
// pixel-strobe samples.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   sync_i       raw sync pin
//   sample_en_i  pixel strobe, already delayed to line up with the second stage
//   fall_o       previous sample 1, current sample 0 (valid only with sample_en_i)

module vga_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    input  logic sample_en_i,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q <= sync_i;
            s2_q <= s1_q;
            if (sample_en_i) begin
                prev_q <= s2_q;
            end
        end
    end

    assign fall_o = sample_en_i & prev_q & ~s2_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
// Measures incoming VGA timing, tracks horizontal/vertical regions and emits
// active-area pixels with coordinates once the timing has matched the configured
// totals for two consecutive frames.
// Optional feature macro: VGA_RX_STATS_EN adds err_cnt (timing mismatch count).
// Ports:
//   clk100, rst_n               clock, synchronous active-low reset
//   pix_en                      pixel strobe (one clk100 cycle per pixel)
//   hsync, vsync                active-low sync inputs
//   red, green, blue            3-bit colour inputs
//   pix_valid, pix_x, pix_y     captured active pixel and its coordinate
//   pix_rgb                     {red,green,blue} of that pixel
//   line_start, frame_start     one-cycle pulses on hsync/vsync falling edges
//   locked                      timing matches the parameters
//   h_total, v_total            last measured line length / frame length
//   err_cnt (VGA_RX_STATS_EN)   saturating count of mismatching total loads

module vga_rx_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic       clk100,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [2:0] blue,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [8:0] pix_rgb,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] h_total,
    output logic [9:0] v_total
`ifdef VGA_RX_STATS_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    // Reference totals are the configured sums (800/525 at default timing).
    localparam logic [9:0] H_TOTAL_REF = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [9:0] V_TOTAL_REF = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [9:0] H_BP_START  = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_FP_START  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_BP_START  = 10'(V_SYNC);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_FP_START  = 10'(V_SYNC + V_BP + V_ACTIVE);

    // Input pipeline: strobe and colour delayed to match the sync edge stages.
    logic       en1_q, en2_q;
    logic [8:0] rgb1_q, rgb2_q;
    logic       hs_fall, vs_fall;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            en1_q  <= 1'b0;
            en2_q  <= 1'b0;
            rgb1_q <= '0;
            rgb2_q <= '0;
        end else begin
            en1_q  <= pix_en;
            en2_q  <= en1_q;
            rgb1_q <= {red, green, blue};
            rgb2_q <= rgb1_q;
        end
    end

    vga_sync_edge u_hs_edge (
        .clk_i       (clk100),
        .rst_ni      (rst_n),
        .sync_i      (hsync),
        .sample_en_i (en2_q),
        .fall_o      (hs_fall)
    );

    vga_sync_edge u_vs_edge (
        .clk_i       (clk100),
        .rst_ni      (rst_n),
        .sync_i      (vsync),
        .sample_en_i (en2_q),
        .fall_o      (vs_fall)
    );

    // Counters and measured totals
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic       h_sat, v_sat;

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_sat         = 1'b0;
        v_sat         = 1'b0;
        if (en2_q) begin
            if (hs_fall) begin
                h_cnt_d      = '0;
                // A saturated count reports 1023 rather than wrapping to 0.
                h_total_d    = sat_inc(h_cnt_q);
                v_cnt_d      = sat_inc(v_cnt_q);
                line_start_d = 1'b1;
            end else begin
                h_cnt_d = sat_inc(h_cnt_q);
            end
            // vsync edge wins over the line increment when both fall together.
            if (vs_fall) begin
                v_cnt_d       = '0;
                v_total_d     = sat_inc(v_cnt_q);
                frame_start_d = 1'b1;
            end
            h_sat = (h_cnt_d == CNT_MAX);
            v_sat = (v_cnt_d == CNT_MAX);
        end
    end

    // Lock tracking: good_cnt counts consecutive clean frames, up to 2.
    // The first edge after reset only starts a measurement and is not judged.
    logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic       bad_q, bad_d;
    logic [1:0] good_q, good_d;
    logic       h_mis, v_mis, lost;

    always_comb begin
        h_mis    = en2_q & hs_fall & h_seen_q & (h_total_d != H_TOTAL_REF);
        v_mis    = en2_q & vs_fall & v_seen_q & (v_total_d != V_TOTAL_REF);
        lost     = h_mis | v_mis | h_sat | v_sat;
        h_seen_d = h_seen_q | (en2_q & hs_fall);
        v_seen_d = v_seen_q | (en2_q & vs_fall);
        bad_d    = bad_q;
        good_d   = good_q;
        if (en2_q) begin
            if (vs_fall) begin
                if (v_seen_q && !lost && !bad_q) begin
                    good_d = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
                end else begin
                    good_d = 2'd0;
                end
                bad_d = 1'b0;
            end else if (lost) begin
                good_d = 2'd0;
                bad_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            bad_q         <= 1'b0;
            good_q        <= 2'd0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            bad_q         <= bad_d;
            good_q        <= good_d;
        end
    end

    // Region FSMs: state register
    h_state_e h_state_q, h_state_d;
    v_state_e v_state_q, v_state_d;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            h_state_q <= H_FP_S;
            v_state_q <= V_FP_S;
        end else begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
        end
    end

    // Region FSMs: next state, judged on the updated counts
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (en2_q) begin
            if (hs_fall) begin
                h_state_d = H_SYNC_S;
            end else begin
                unique case (h_state_q)
                    H_SYNC_S: if (h_cnt_d == H_BP_START)  h_state_d = H_BP_S;
                    H_BP_S:   if (h_cnt_d == H_ACT_START) h_state_d = H_ACT_S;
                    H_ACT_S:  if (h_cnt_d == H_FP_START)  h_state_d = H_FP_S;
                    H_FP_S:   h_state_d = H_FP_S;
                endcase
            end
            if (vs_fall) begin
                v_state_d = V_SYNC_S;
            end else begin
                unique case (v_state_q)
                    V_SYNC_S: if (v_cnt_d == V_BP_START)  v_state_d = V_BP_S;
                    V_BP_S:   if (v_cnt_d == V_ACT_START) v_state_d = V_ACT_S;
                    V_ACT_S:  if (v_cnt_d == V_FP_START)  v_state_d = V_FP_S;
                    V_FP_S:   v_state_d = V_FP_S;
                endcase
            end
        end
    end

    // Region FSMs: pixel outputs. Coordinates/colour hold their last capture.
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [8:0] pix_rgb_q, pix_rgb_d;

    always_comb begin
        pix_valid_d = en2_q & (good_d == 2'd2) & (h_state_d == H_ACT_S) &
                      (v_state_d == V_ACT_S);
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_rgb_d   = pix_rgb_q;
        if (pix_valid_d) begin
            pix_x_d   = h_cnt_d - H_ACT_START;
            pix_y_d   = v_cnt_d - V_ACT_START;
            pix_rgb_d = rgb2_q;
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_rgb_q   <= '0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_rgb_q   <= pix_rgb_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = (good_q == 2'd2);
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;

`ifdef VGA_RX_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + {16'd0, h_mis} + {16'd0, v_mis};
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced timing (16x8 totals) so
// whole frames stay short.

module tb_vga_rx_monitor;

    localparam int TB_H_ACTIVE = 8;
    localparam int TB_H_FP     = 2;
    localparam int TB_H_SYNC   = 3;
    localparam int TB_H_BP     = 3;
    localparam int TB_V_ACTIVE = 4;
    localparam int TB_V_FP     = 1;
    localparam int TB_V_SYNC   = 1;
    localparam int TB_V_BP     = 2;
    localparam int TB_HT       = 16;
    localparam int TB_VT       = 8;

    logic       clk100 = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic       hsync, vsync;
    logic [2:0] red, green, blue;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [8:0] pix_rgb;
    logic       line_start, frame_start, locked;
    logic [9:0] h_total, v_total;
`ifdef VGA_RX_STATS_EN
    logic [15:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_line = 0, n_frame = 0;
    int s_valid, s_line, s_frame;

    always #5 clk100 = ~clk100;

    vga_rx_monitor #(
        .H_ACTIVE (TB_H_ACTIVE),
        .H_FP     (TB_H_FP),
        .H_SYNC   (TB_H_SYNC),
        .H_BP     (TB_H_BP),
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FP     (TB_V_FP),
        .V_SYNC   (TB_V_SYNC),
        .V_BP     (TB_V_BP)
    ) dut (
        .clk100      (clk100),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .h_total     (h_total),
        .v_total     (v_total)
`ifdef VGA_RX_STATS_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always @(negedge clk100) begin
        if (pix_valid)   n_valid <= n_valid + 1;
        if (line_start)  n_line  <= n_line + 1;
        if (frame_start) n_frame <= n_frame + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] rgb_of(input int l, input int p);
        return 9'((l * 37 + p * 11 + 5) % 512);
    endfunction

    // One pixel: strobe for a cycle, then three idle cycles. On return the
    // DUT outputs for this pixel are visible and any pulse is still high.
    task automatic send_px(input logic hs, input logic vs, input logic [8:0] rgb);
        @(negedge clk100);
        pix_en = 1'b1;
        hsync  = hs;
        vsync  = vs;
        {red, green, blue} = rgb;
        @(negedge clk100);
        pix_en = 1'b0;
        @(negedge clk100);
        @(negedge clk100);
    endtask

    task automatic send_line(input int l, input int len, input int p0);
        for (int p = p0; p < len; p++) begin
            send_px((p < TB_H_SYNC) ? 1'b0 : 1'b1, (l < TB_V_SYNC) ? 1'b0 : 1'b1,
                    rgb_of(l, p));
        end
    endtask

    task automatic send_frame();
        for (int l = 0; l < TB_VT; l++) send_line(l, TB_HT, 0);
    endtask

    task automatic send_first_px();
        send_px(1'b0, 1'b0, rgb_of(0, 0));
    endtask

    task automatic send_frame_tail();
        send_line(0, TB_HT, 1);
        for (int l = 1; l < TB_VT; l++) send_line(l, TB_HT, 0);
    endtask

    // First active pixel with cycle-exact latency checks.
    task automatic send_probe(input logic [8:0] rgb);
        @(negedge clk100);
        pix_en = 1'b1;
        hsync  = 1'b1;
        vsync  = 1'b1;
        {red, green, blue} = rgb;
        @(negedge clk100);
        pix_en = 1'b0;
        @(posedge clk100);
        #1;
        check("probe_valid_at_2", 32'(pix_valid), 32'd0);
        @(posedge clk100);
        #1;
        check("probe_valid_at_3", 32'(pix_valid), 32'd1);
        check("probe_x", 32'(pix_x), 32'd0);
        check("probe_y", 32'(pix_y), 32'd0);
        check("probe_rgb", 32'(pix_rgb), 32'h1A5);
        @(negedge clk100);
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        {red, green, blue} = 9'd0;
        repeat (3) @(negedge clk100);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_h_total", 32'(h_total), 32'd0);
        check("rst_v_total", 32'(v_total), 32'd0);
        check("rst_pulses", 32'({line_start, frame_start}), 32'd0);
        rst_n = 1'b1;

        // Idle lead-in so the first sync fall is seen as an edge.
        repeat (4) send_px(1'b1, 1'b1, 9'd0);

        send_frame();
        send_frame();
        check("f2_h_total", 32'(h_total), 32'(TB_HT));
        check("f2_v_total", 32'(v_total), 32'(TB_VT));
        check("f2_not_locked", 32'(locked), 32'd0);

        // Frame 3: lock rises on its first sample, coincident edges.
        #2;
        s_valid = n_valid;
        s_line  = n_line;
        s_frame = n_frame;
        send_first_px();
        check("f3_locked", 32'(locked), 32'd1);
        check("f3_line_start", 32'(line_start), 32'd1);
        check("f3_frame_start", 32'(frame_start), 32'd1);
        check("f3_h_cnt", 32'(dut.h_cnt_q), 32'd0);
        check("f3_v_cnt", 32'(dut.v_cnt_q), 32'd0);
        send_line(0, TB_HT, 1);
        for (int l = 1; l < 3; l++) send_line(l, TB_HT, 0);
        send_line(3, 6, 0);
        send_probe(9'h1A5);
        send_line(3, TB_HT, 7);
        for (int l = 4; l < TB_VT; l++) send_line(l, TB_HT, 0);
        #2;
        check("f3_valid_count", 32'(n_valid - s_valid), 32'd32);
        check("f3_line_count", 32'(n_line - s_line), 32'd8);
        check("f3_frame_count", 32'(n_frame - s_frame), 32'd1);
        check("f3_last_x", 32'(pix_x), 32'd7);
        check("f3_last_y", 32'(pix_y), 32'd3);

        // Frame 4: one short line.
        send_first_px();
        send_line(0, TB_HT, 1);
        for (int l = 1; l < 5; l++) send_line(l, TB_HT, 0);
        check("f4_locked_before", 32'(locked), 32'd1);
        send_line(5, TB_HT - 1, 0);
        send_px(1'b0, 1'b1, rgb_of(6, 0));
        check("short_h_total", 32'(h_total), 32'(TB_HT - 1));
        check("short_unlocked", 32'(locked), 32'd0);
`ifdef VGA_RX_STATS_EN
        check("short_err_cnt", 32'(err_cnt), 32'd1);
`endif
        send_line(6, TB_HT, 1);
        send_line(7, TB_HT, 0);

        // Relock needs two clean frames.
        send_frame();
        send_frame();
        check("f6_not_locked", 32'(locked), 32'd0);
        send_first_px();
        check("f7_relocked", 32'(locked), 32'd1);

        // hsync held high: counter saturates and lock drops.
        #2;
        s_line = n_line;
        repeat (1100) send_px(1'b1, 1'b1, 9'd0);
        #2;
        check("sat_h_cnt", 32'(dut.h_cnt_q), 32'd1023);
        check("sat_unlocked", 32'(locked), 32'd0);
        check("sat_no_line_start", 32'(n_line - s_line), 32'd0);

        send_frame();
        send_frame();
        send_first_px();
        check("f10_locked", 32'(locked), 32'd1);

        // Reset mid active area.
        send_line(0, TB_HT, 1);
        for (int l = 1; l < 3; l++) send_line(l, TB_HT, 0);
        send_line(3, 9, 0);
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        check("pre_rst_x", 32'(pix_x), 32'd2);
        @(negedge clk100);
        rst_n = 1'b0;
        @(negedge clk100);
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_xy", 32'({pix_x, pix_y}), 32'd0);
        check("mid_rst_rgb", 32'(pix_rgb), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_totals", 32'({h_total, v_total}), 32'd0);
`ifdef VGA_RX_STATS_EN
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        send_line(3, TB_HT, 9);
        for (int l = 4; l < TB_VT; l++) send_line(l, TB_HT, 0);
        send_frame();
        send_first_px();
        check("f12_not_locked", 32'(locked), 32'd0);
        send_frame_tail();
        send_first_px();
        check("f13_locked", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 Ports: clk100  in  1  single system clock, all logic on rising edge.
REQ-006 Ports: rst_n  in  1  reset, synchronous and active-low.
REQ-007 Ports: pix_en  in  1  pixel strobe, one clk100 cycle per pixel (25 MHz at default timing).
REQ-008 Ports: hsync, vsync  in  1 each  sync inputs, active-low.
REQ-009 Ports: red, green, blue  in  3 each  pixel colour.
REQ-010 Ports: pix_valid  out  1  captured active-area pixel this cycle.
REQ-011 Ports: pix_x, pix_y  out  10 each  pixel coordinate.
REQ-012 Ports: pix_rgb  out  9  {red,green,blue} of the captured pixel.
REQ-013 Ports: line_start, frame_start  out  1 each  single-cycle pulses.
REQ-014 Ports: locked  out  1  timing matches parameters.
REQ-015 Ports: h_total, v_total  out  10 each  last measured line length (pixels) and frame length (lines).

Function
REQ-016 SHALL pass hsync, vsync, rgb and pix_en through two register stages; all logic uses the delayed copies.
REQ-017 SHALL update state only on delayed pix_en cycles.
REQ-018 hsync falling edge (previous sample 1, current 0) SHALL clear h_cnt to 0, load h_total with h_cnt+1, and pulse line_start.
REQ-019 h_cnt SHALL otherwise increment per pixel, saturating at 1023.
REQ-020 v_cnt SHALL increment on each hsync falling edge and saturate at 1023.
REQ-021 vsync falling edge SHALL clear v_cnt to 0, load v_total with v_cnt+1, and pulse frame_start.
REQ-022 When both edges fall in the same sample, v_cnt SHALL be 0 and h_cnt SHALL be 0.
REQ-023 Horizontal region FSM SHALL have states H_SYNC_S -> H_BP_S -> H_ACT_S -> H_FP_S, advancing on h_cnt boundaries 0, H_SYNC, H_SYNC+H_BP, and H_SYNC+H_BP+H_ACTIVE.
REQ-024 Vertical region FSM SHALL have states V_SYNC_S -> V_BP_S -> V_ACT_S -> V_FP_S on the analogous v_cnt boundaries.
REQ-025 Any sync edge SHALL force the corresponding FSM to its SYNC state regardless of current state.
REQ-026 pix_valid SHALL be 1 iff locked, H_ACT_S and V_ACT_S hold; then pix_x = h_cnt-(H_SYNC+H_BP), pix_y = v_cnt-(V_SYNC+V_BP), and pix_rgb holds the sample.
REQ-027 Latency from input pins to pix_valid/pix_rgb SHALL be 3 clk100 cycles.
REQ-028 locked SHALL set after two consecutive frames in which every h_total equals 800 (the default sum) and v_total equals 525 (the default sum).
REQ-029 locked SHALL clear in the cycle after any mismatching h_total or v_total load, or when h_cnt or v_cnt saturates at 1023 (lost sync).
REQ-030 Outputs not listed in REQ-026 SHALL hold their value between pix_en cycles; pulses SHALL last one clk100 cycle.

Reset
REQ-031 While rst_n=0 at a clock edge, all registers SHALL clear, outputs SHALL be 0, and the FSMs SHALL enter H_FP_S/V_FP_S.
REQ-032 Reset mid-frame SHALL require a fresh two-frame lock.

Configuration
REQ-033 With VGA_RX_STATS_EN defined: add output err_cnt (16 bits), which increments on each mismatching h_total/v_total load, saturates at 65535, and clears on reset.
REQ-034 Without VGA_RX_STATS_EN: err_cnt is absent and no counter logic is present.

Structure
REQ-035 Package vga_timing_pkg SHALL hold the default timing constants and the H/V region state enum.
REQ-036 Sub-module vga_sync_edge SHALL do the two-stage delay and falling-edge detect, instanced once per sync input.

Verification
REQ-037 Two frames of default 640x480 timing -> locked rises at the start of frame 3; pix_valid count per frame = 307200.
REQ-038 In a locked frame, a pixel at the first active position -> pix_x=0, pix_y=0, pix_rgb matches, 3 cycles after the input.
REQ-039 One line of 799 pixels -> h_total=799, locked=0 on the next cycle, err_cnt=1 with VGA_RX_STATS_EN.
REQ-040 Hsync held high for 1100 pixels -> h_cnt saturates, locked=0, line_start not pulsed.
REQ-041 Coincident hsync/vsync falling edges -> line_start and frame_start pulse together, h_cnt=v_cnt=0.
REQ-042 rst_n=0 for 1 cycle mid-active-area -> all outputs 0 next cycle, relock after two frames.
